fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the PC, drives the instruction-memory request, and fills the IF/ID latch whose instruction word feeds the decode-stage control unit. Branch, jump and jump-register instructions resolve in EX; this block takes their redirect, computes the target, and flushes wrong-path fetches. A one-entry skid buffer absorbs a fetch that returns while decode is stalled.

## Interface
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

- CLK  in  1  pipeline clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  instruction memory returns iload this cycle
- iload  in  32  instruction word
- iREN  out  1  instruction read request
- iaddr  out  32  instruction address (= PC)
- stall  in  1  hazard unit: hold IF/ID and PC (load-use)
- halt  in  1  HALT decoded; stop fetching permanently
- ex_valid  in  1  EX holds a real (non-bubble) instruction
- ex_pcsrc  in  3  EX PC-source code: 0 seq, 1 jr, 2 j/jal, 3 beq, 4 bne, 5-7 seq
- ex_npc  in  32  PC+4 of the EX instruction
- ex_imm  in  26  instr[25:0] of the EX instruction
- ex_rsdata  in  32  forwarded rs value in EX
- ex_zero  in  1  ALU zero flag (rs-rt) in EX
- ifid_instr  out  32  IF/ID instruction
- ifid_npc  out  32  IF/ID PC+4
- ifid_valid  out  1  IF/ID holds a real instruction
- flush  out  1  redirect taken; ID/EX must load a bubble

## Operation
- Redirect (combinational): taken = ex_valid & (pcsrc==1 | pcsrc==2 | (pcsrc==3 & ex_zero) | (pcsrc==4 & !ex_zero)). flush = taken.
- Targets: jr → ex_rsdata; j → {ex_npc[31:28], ex_imm, 2'b00}; beq/bne → ex_npc + sign-extended {ex_imm[15:0], 2'b00}. All 32-bit, wrapping mod 2^32; no overflow detection.
- States: FETCH (reset state), HOLD (skid buffer full), HALTED.
- iREN = 1 in FETCH, 0 in HOLD and HALTED. iaddr = PC always.
- FETCH, ihit & !stall: IF/ID ← {iload, PC+4, valid=1}; PC ← PC+4.
- FETCH, ihit & stall: skid ← {iload, PC+4}; PC ← PC+4; → HOLD. IF/ID unchanged.
- FETCH, !ihit & !stall: ifid_valid ← 0 (bubble). !ihit & stall: IF/ID unchanged.
- HOLD, !stall: IF/ID ← skid, valid=1; → FETCH. HOLD, stall: no change.
- Priority, highest first: RST, taken, halt, normal. taken in any state except HALTED: PC ← target, ifid_valid ← 0, skid discarded, → FETCH; a simultaneous ihit is dropped; stall is ignored.
- halt (no taken): → HALTED, ifid_valid ← 0, PC frozen. HALTED exits only via RST.
- PC+4 wraps 32'hFFFF_FFFC → 32'h0000_0000.

## Timing
- Reset (async, immediate): PC = PC_INIT, state FETCH, ifid_instr = 0, ifid_npc = 0, ifid_valid = 0, skid empty. Hence iREN = 1 and iaddr = PC_INIT while RST is high. flush follows EX inputs combinationally.
- RST asserted mid-fetch or mid-HOLD discards all in-flight state; there is no recovery of the buffered word.
- Fetch latency: ihit in cycle n → ifid_valid = 1 at edge n+1, iaddr = old PC+4 in cycle n+1.
- Redirect penalty: taken in cycle n → iaddr = target in cycle n+1. IF/ID and ID/EX are bubbled; 2 lost slots.
- Stall release with skid full: word appears in IF/ID one edge after stall falls; iREN resumes the cycle after that.
- Throughput: one instruction per cycle when ihit is held high and stall is low.

## Test plan
- Sequential: PC_INIT=0, ihit=1, iload=PC-tagged words for 4 cycles → ifid_npc = 4,8,12,16, ifid_valid = 1, iaddr = 4,8,12,16.
- Stall/skid: stall=1 while ihit=1 at PC=8 → state HOLD, iREN=0, IF/ID unchanged. Drop stall → ifid_instr = word@8, ifid_npc=12, then iaddr=12 with iREN=1.
- BEQ taken / BNE not taken: ex_pcsrc=3, ex_zero=1, ex_npc=0x40, ex_imm[15:0]=0xFFFE → flush=1, next iaddr=0x38, ifid_valid=0. ex_pcsrc=4 with ex_zero=1 → flush=0, PC advances by 4.
- J/JR: pcsrc=2, ex_npc=0x8000_0010, ex_imm=0x0000100 → iaddr=0x8000_0400. pcsrc=1, ex_rsdata=0x1234 → iaddr=0x1234. Redirect concurrent with stall=1 and ihit=1 → redirect wins, fetched word is dropped.
- Halt: halt=1 → iREN=0 and ifid_valid=0 from the next edge onward, PC frozen. A later taken redirect is ignored. RST pulse → iaddr=PC_INIT, iREN=1.
- Wrap and async reset: PC=0xFFFF_FFFC with ihit → PC=0. Assert RST between edges → outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: owns the PC, fills IF/ID, takes EX redirects.
// One-cycle fetch latency; stall parks a returning word in a one-entry skid and drops iREN.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        stall,
    input  logic        halt,
    input  logic        ex_valid,
    input  logic [2:0]  ex_pcsrc,
    input  logic [31:0] ex_npc,
    input  logic [25:0] ex_imm,
    input  logic [31:0] ex_rsdata,
    input  logic        ex_zero,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic        flush
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        HALTED
    } state_e;

    localparam logic [2:0] PCSRC_JR  = 3'd1;
    localparam logic [2:0] PCSRC_J   = 3'd2;
    localparam logic [2:0] PCSRC_BEQ = 3'd3;
    localparam logic [2:0] PCSRC_BNE = 3'd4;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_npc_q, ifid_npc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_npc_q, skid_npc_d;

    logic        taken;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] br_off;

    assign pc_plus4 = pc_q + 32'd4;
    assign br_off   = {{14{ex_imm[15]}}, ex_imm[15:0], 2'b00};

    always_comb begin
        taken = 1'b0;
        if (ex_valid) begin
            case (ex_pcsrc)
                PCSRC_JR:  taken = 1'b1;
                PCSRC_J:   taken = 1'b1;
                PCSRC_BEQ: taken = ex_zero;
                PCSRC_BNE: taken = ~ex_zero;
                default:   taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (ex_pcsrc)
            PCSRC_JR: target = ex_rsdata;
            PCSRC_J:  target = {ex_npc[31:28], ex_imm, 2'b00};
            default:  target = ex_npc + br_off;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_npc_d   = ifid_npc_q;
        ifid_valid_d = ifid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_npc_d   = skid_npc_q;

        // HALTED is sticky: neither redirects nor fetches may leave it.
        if (state_q != HALTED && taken) begin
            pc_d         = target;
            ifid_valid_d = 1'b0;
            state_d      = FETCH;
        end else if (state_q != HALTED && halt) begin
            ifid_valid_d = 1'b0;
            state_d      = HALTED;
        end else begin
            case (state_q)
                FETCH: begin
                    if (ihit && !stall) begin
                        ifid_instr_d = iload;
                        ifid_npc_d   = pc_plus4;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_plus4;
                    end else if (ihit && stall) begin
                        skid_instr_d = iload;
                        skid_npc_d   = pc_plus4;
                        pc_d         = pc_plus4;
                        state_d      = HOLD;
                    end else if (!stall) begin
                        ifid_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_instr_d = skid_instr_q;
                        ifid_npc_d   = skid_npc_q;
                        ifid_valid_d = 1'b1;
                        state_d      = FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= FETCH;
            pc_q         <= PC_INIT;
            ifid_instr_q <= 32'd0;
            ifid_npc_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
            skid_instr_q <= 32'd0;
            skid_npc_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_npc_q   <= ifid_npc_d;
            ifid_valid_q <= ifid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_npc_q   <= skid_npc_d;
        end
    end

    assign iREN       = (state_q == FETCH);
    assign iaddr      = pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_npc   = ifid_npc_q;
    assign ifid_valid = ifid_valid_q;
    assign flush      = taken;

endmodule
